// File: rtl/pwm_pkg.sv
// Shared PWM definitions: state encoding and default geometry of the
// compare-and-count stage, reused by the ramp controller and compycont benches.
package pwm_pkg;

   localparam int PWM_WIDTH    = 10;
   localparam int PWM_PERIOD   = 1024;
   localparam int PWM_STEP     = 8;
   localparam int PWM_DUTY_MAX = 1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_HOLD = 2'd2
   } pwm_state_e;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter; runs only while enabled and flags the
// last cycle of every period so duty updates land on period boundaries.
module pwm_period_timer
   import pwm_pkg::*;
#(
   parameter int WIDTH  = PWM_WIDTH,
   parameter int PERIOD = PWM_PERIOD
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic period_end
);

   localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(PERIOD - 1);

   logic [WIDTH-1:0] pcnt_r;
   logic             last_s;

   assign last_s = (pcnt_r == LAST_CNT);

   // period counter: cleared while disabled, wraps after the last cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt_r <= {WIDTH{1'b0}};
      end else if (!enable || last_s) begin
         pcnt_r <= {WIDTH{1'b0}};
      end else begin
         pcnt_r <= pcnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign period_end = enable & last_s;

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start duty controller for the compycont PWM stage: accepts a target over
// valid/ready and slews the registered duty toward it by STEP per period.
module pwm_duty_ramp_ctrl
   import pwm_pkg::*;
#(
   parameter int WIDTH    = PWM_WIDTH,
   parameter int PERIOD   = PWM_PERIOD,
   parameter int STEP     = PWM_STEP,
   parameter int DUTY_MAX = PWM_DUTY_MAX
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             tgt_valid,
   input  logic [WIDTH-1:0] tgt_data,
   output logic             tgt_ready,
   output logic [WIDTH-1:0] duty,
   output logic             period_end,
   output logic             busy,
   output logic             at_target
);

   localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(DUTY_MAX);
   localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

   pwm_state_e       state_r, state_nxt_s;
   logic [WIDTH-1:0] duty_r, target_r;
   logic [WIDTH-1:0] clamp_s, tgt_eff_s, ramp_duty_s;
   logic [WIDTH:0]   diff_s, step_s, duty_step_s;
   logic             up_s, pe_s, accept_s;
   logic             tgt_ready_s, busy_s, at_target_s;

   pwm_period_timer #(
      .WIDTH  (WIDTH),
      .PERIOD (PERIOD)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .period_end (pe_s)
   );

   assign accept_s = tgt_valid & tgt_ready_s;

   // target clamp; IDLE decides on the word being accepted this very cycle
   always_comb begin
      if ({1'b0, tgt_data} > MAX_W) begin
         clamp_s = MAX_W[WIDTH-1:0];
      end else begin
         clamp_s = tgt_data;
      end
      if (accept_s) begin
         tgt_eff_s = clamp_s;
      end else begin
         tgt_eff_s = target_r;
      end
   end

   // ramp step: unsigned WIDTH+1 distance, step limited to the remaining gap
   always_comb begin
      up_s = ({1'b0, target_r} >= {1'b0, duty_r});
      if (up_s) begin
         diff_s = {1'b0, target_r} - {1'b0, duty_r};
      end else begin
         diff_s = {1'b0, duty_r} - {1'b0, target_r};
      end
      if (diff_s < STEP_W) begin
         step_s = diff_s;
      end else begin
         step_s = STEP_W;
      end
      if (up_s) begin
         duty_step_s = {1'b0, duty_r} + step_s;
      end else begin
         duty_step_s = {1'b0, duty_r} - step_s;
      end
      if (duty_step_s > MAX_W) begin
         ramp_duty_s = MAX_W[WIDTH-1:0];
      end else begin
         ramp_duty_s = duty_step_s[WIDTH-1:0];
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      if (!enable) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (tgt_eff_s != {WIDTH{1'b0}}) begin
                  state_nxt_s = ST_RAMP;
               end else begin
                  state_nxt_s = ST_HOLD;
               end
            end
            ST_RAMP: begin
               if (pe_s && (ramp_duty_s == target_r)) begin
                  state_nxt_s = ST_HOLD;
               end else begin
                  state_nxt_s = ST_RAMP;
               end
            end
            ST_HOLD: begin
               if (accept_s && (clamp_s != duty_r)) begin
                  state_nxt_s = ST_RAMP;
               end else begin
                  state_nxt_s = ST_HOLD;
               end
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // FSM outputs decoded from the state register
   always_comb begin
      tgt_ready_s = 1'b0;
      busy_s      = 1'b0;
      at_target_s = 1'b0;
      case (state_r)
         ST_IDLE: tgt_ready_s = 1'b1;
         ST_RAMP: busy_s      = 1'b1;
         ST_HOLD: begin
            tgt_ready_s = 1'b1;
            at_target_s = 1'b1;
         end
         default: tgt_ready_s = 1'b0;
      endcase
   end

   // target and duty registers; target survives a disable, duty does not
   always_ff @(posedge clk) begin
      if (reset) begin
         target_r <= {WIDTH{1'b0}};
         duty_r   <= {WIDTH{1'b0}};
      end else begin
         if (accept_s) begin
            target_r <= clamp_s;
         end else begin
            target_r <= target_r;
         end
         if (!enable || (state_r == ST_IDLE)) begin
            duty_r <= {WIDTH{1'b0}};
         end else if ((state_r == ST_RAMP) && pe_s) begin
            duty_r <= ramp_duty_s;
         end else begin
            duty_r <= duty_r;
         end
      end
   end

   assign tgt_ready  = tgt_ready_s;
   assign duty       = duty_r;
   assign period_end = pe_s;
   assign busy       = busy_s;
   assign at_target  = at_target_s;

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed self-checking bench for pwm_duty_ramp_ctrl with a 16-cycle period,
// STEP=100 and DUTY_MAX=1000; expected duty sequences are hand-computed.
module tb_pwm_duty_ramp_ctrl;

   logic       clk = 1'b0;
   logic       reset, enable, tgt_valid;
   logic [9:0] tgt_data;
   logic       tgt_ready, period_end, busy, at_target;
   logic [9:0] duty;

   int checks   = 0;
   int failures = 0;

   pwm_duty_ramp_ctrl #(
      .WIDTH    (10),
      .PERIOD   (16),
      .STEP     (100),
      .DUTY_MAX (1000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .tgt_valid  (tgt_valid),
      .tgt_data   (tgt_data),
      .tgt_ready  (tgt_ready),
      .duty       (duty),
      .period_end (period_end),
      .busy       (busy),
      .at_target  (at_target)
   );

   always #5 clk = ~clk;

   int seq1[8] = '{100, 200, 300, 400, 500, 600, 700, 725};
   int seq2[7] = '{625, 525, 425, 325, 225, 125, 100};
   int seq3[9] = '{200, 300, 400, 500, 600, 700, 800, 900, 1000};
   int seq4[7] = '{900, 800, 700, 600, 500, 400, 300};
   int seq5[5] = '{300, 400, 500, 600, 700};
   int seq6[3] = '{600, 500, 400};

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // stop at a negedge where period_end is high, without taking that edge
   task automatic wait_pe(output int n);
      n = 0;
      while (period_end !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      if (n >= 40) check_eq("pe_timeout", int'(period_end), 1);
   endtask

   task automatic tick(output int n);
      wait_pe(n);
      step();
      n++;
   endtask

   task automatic offer(input int v);
      tgt_valid = 1'b1;
      tgt_data  = 10'(v);
      check_eq("offer_ready", int'(tgt_ready), 1);
      step();
      tgt_valid = 1'b0;
      check_eq("accept_busy", int'(busy), 1);
   endtask

   task automatic check_reset_outs(input string tag);
      check_eq({tag, "_duty"}, int'(duty), 0);
      check_eq({tag, "_busy"}, int'(busy), 0);
      check_eq({tag, "_at_target"}, int'(at_target), 0);
      check_eq({tag, "_ready"}, int'(tgt_ready), 1);
      check_eq({tag, "_pe"}, int'(period_end), 0);
   endtask

   initial begin
      int n;
      reset = 1'b1; enable = 1'b0; tgt_valid = 1'b0; tgt_data = 10'd0;
      @(negedge clk);
      step();
      check_reset_outs("reset");

      // 1: soft start to 725
      reset  = 1'b0;
      enable = 1'b1;
      offer(725);
      check_eq("t1_ready_ramp", int'(tgt_ready), 0);
      foreach (seq1[i]) begin
         tick(n);
         check_eq("t1_period", n, (i == 0) ? 15 : 16);
         check_eq("t1_duty", int'(duty), seq1[i]);
         check_eq("t1_busy", int'(busy), (i < 7) ? 1 : 0);
         check_eq("t1_at_target", int'(at_target), (i < 7) ? 0 : 1);
      end

      // 2: ramp down to 100
      offer(100);
      foreach (seq2[i]) begin
         tick(n);
         check_eq("t2_duty", int'(duty), seq2[i]);
      end
      check_eq("t2_at_target", int'(at_target), 1);

      // 3: oversize target clamps to 1000
      offer(1023);
      foreach (seq3[i]) begin
         tick(n);
         check_eq("t3_duty", int'(duty), seq3[i]);
      end
      check_eq("t3_at_target", int'(at_target), 1);
      tick(n);
      check_eq("t3_duty_hold", int'(duty), 1000);

      // 4: disable mid-ramp at 300, then resume toward retained 200
      offer(200);
      foreach (seq4[i]) begin
         tick(n);
         check_eq("t4_duty", int'(duty), seq4[i]);
      end
      enable = 1'b0;
      step();
      check_eq("t4_off_duty", int'(duty), 0);
      check_eq("t4_off_busy", int'(busy), 0);
      check_eq("t4_off_ready", int'(tgt_ready), 1);
      step();
      enable = 1'b1;
      tick(n);
      check_eq("t4_resume_period", n, 16);
      check_eq("t4_resume_duty", int'(duty), 100);
      check_eq("t4_resume_busy", int'(busy), 1);
      tick(n);
      check_eq("t4_final_duty", int'(duty), 200);
      check_eq("t4_at_target", int'(at_target), 1);

      // 5: target held during RAMP is only taken in HOLD
      offer(700);
      tgt_valid = 1'b1;
      tgt_data  = 10'd400;
      foreach (seq5[i]) begin
         check_eq("t5_ready_ramp", int'(tgt_ready), 0);
         tick(n);
         check_eq("t5_duty", int'(duty), seq5[i]);
      end
      check_eq("t5_ready_hold", int'(tgt_ready), 1);
      step();
      tgt_valid = 1'b0;
      check_eq("t5_busy", int'(busy), 1);
      foreach (seq6[i]) begin
         tick(n);
         check_eq("t5_duty2", int'(duty), seq6[i]);
      end
      check_eq("t5_at_target", int'(at_target), 1);

      // 6: reset pulse mid-ramp, then accept coinciding with period_end
      offer(900);
      tick(n);
      check_eq("t6_duty", int'(duty), 500);
      step();
      step();
      reset = 1'b1;
      step();
      check_reset_outs("t6_reset");
      reset = 1'b0;
      step();
      check_eq("t6_hold_zero", int'(at_target), 1);
      wait_pe(n);
      tgt_valid = 1'b1;
      tgt_data  = 10'd100;
      step();
      tgt_valid = 1'b0;
      check_eq("t6_sim_duty", int'(duty), 0);
      check_eq("t6_sim_busy", int'(busy), 1);
      tick(n);
      check_eq("t6_sim_period", n, 16);
      check_eq("t6_sim_final", int'(duty), 100);
      check_eq("t6_sim_at_target", int'(at_target), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
